// File: rtl/cpu_dmem.sv
// cpu_dmem: internal data memory controller for the qwic51 core.
//
// Addresses below SFR_BASE hit an on-chip synchronous RAM. Addresses at or above it go to an
// external SFR bus. A read on that bus is held until the bus returns valid data or a timeout
// expires. A bit write (MEM_WR with MEM_BIT) is carried out as a read-modify-write sequence.
//
// Ports:
//   CLK, RST_N          clock; synchronous active-low reset
//   MEM_ADDR            request address
//   MEM_WR_DATA         word write data
//   MEM_WR, MEM_RD      write / read request, accepted when MEM_BUSY is low
//   MEM_BIT             turns MEM_WR into a bit write
//   MEM_BIT_IDX         index of the bit to modify
//   MEM_BIT_VAL         new value of that bit
//   MEM_BUSY            high while a multi-cycle sequence is in progress
//   MEM_RD_DATA         read data, held until the next MEM_RD_VALID
//   MEM_RD_VALID        one-cycle strobe qualifying MEM_RD_DATA
//   MEM_ERR             one-cycle strobe when an SFR read times out
//   SFR_ADDR            SFR bus address
//   SFR_WR_DATA         SFR bus write data
//   SFR_WR              one-cycle SFR write strobe
//   SFR_RD              SFR read request, held until valid or timeout
//   SFR_RD_DATA         SFR bus read data
//   SFR_RD_VALID        SFR bus read data valid
module cpu_dmem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned SFR_BASE   = 128,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [ADDR_WIDTH-1:0]         MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]         MEM_WR_DATA,
  input  logic                          MEM_WR,
  input  logic                          MEM_RD,
  input  logic                          MEM_BIT,
  input  logic [$clog2(DATA_WIDTH)-1:0] MEM_BIT_IDX,
  input  logic                          MEM_BIT_VAL,
  output logic                          MEM_BUSY,
  output logic [DATA_WIDTH-1:0]         MEM_RD_DATA,
  output logic                          MEM_RD_VALID,
  output logic                          MEM_ERR,
  output logic [ADDR_WIDTH-1:0]         SFR_ADDR,
  output logic [DATA_WIDTH-1:0]         SFR_WR_DATA,
  output logic                          SFR_WR,
  output logic                          SFR_RD,
  input  logic [DATA_WIDTH-1:0]         SFR_RD_DATA,
  input  logic                          SFR_RD_VALID
);

  localparam int unsigned BW     = $clog2(DATA_WIDTH);
  localparam int unsigned RAM_AW = (SFR_BASE > 1) ? $clog2(SFR_BASE) : 1;
  localparam int unsigned CW     = $clog2(TIMEOUT + 1);

  // One extra bit so SFR_BASE == 2**ADDR_WIDTH (no SFR space) is representable.
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH + 1)'(SFR_BASE);
  localparam logic [CW-1:0]       CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRamRmw, StSfrWait, StSfrWb} state_e;

  state_e state_q, state_d;

  logic                  accept;
  logic                  is_ram;
  logic                  is_bit_wr;
  logic                  timeout_hit;

  logic [CW-1:0]         cnt_q;
  logic                  bit_q;
  logic [BW-1:0]         idx_q;
  logic                  val_q;
  logic [RAM_AW-1:0]     rmw_addr_q;
  logic [DATA_WIDTH-1:0] rmw_word_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] sfr_addr_q;
  logic [DATA_WIDTH-1:0] sfr_wr_data_q;

  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [RAM_AW-1:0]     ram_raddr;

  logic [DATA_WIDTH-1:0] ram [SFR_BASE];

  function automatic logic [DATA_WIDTH-1:0] set_bit(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [BW-1:0]         idx,
                                                    input logic                  val);
    logic [DATA_WIDTH-1:0] r;
    r      = word;
    r[idx] = val;
    return r;
  endfunction

  always_comb begin
    accept      = (MEM_RD | MEM_WR) & (state_q == StIdle);
    is_ram      = {1'b0, MEM_ADDR} < BASE_EXT;
    // MEM_BIT only matters for writes; with MEM_RD alone it is a plain read.
    is_bit_wr   = MEM_WR & MEM_BIT;
    timeout_hit = (cnt_q == CNT_LAST);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_ram) begin
            if (is_bit_wr) state_d = StRamRmw;
          end else if (MEM_WR && !MEM_BIT) begin
            state_d = StSfrWb;
          end else begin
            // SFR read, or SFR bit write which must read the register first.
            state_d = StSfrWait;
          end
        end
      end
      StRamRmw: state_d = StIdle;
      StSfrWait: begin
        if (SFR_RD_VALID) begin
          state_d = bit_q ? StSfrWb : StIdle;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StSfrWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    MEM_BUSY     = (state_q != StIdle);
    SFR_RD       = (state_q == StSfrWait);
    SFR_WR       = (state_q == StSfrWb);
    MEM_RD_DATA  = rd_data_q;
    MEM_RD_VALID = rd_valid_q;
    MEM_ERR      = err_q;
    SFR_ADDR     = sfr_addr_q;
    SFR_WR_DATA  = sfr_wr_data_q;
  end

  // RAM port control. Writes are gated by RST_N so a reset abandons a pending write-back.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = MEM_ADDR[RAM_AW-1:0];
    ram_wdata = MEM_WR_DATA;
    ram_raddr = MEM_ADDR[RAM_AW-1:0];
    if (RST_N) begin
      if (state_q == StRamRmw) begin
        ram_we    = 1'b1;
        ram_waddr = rmw_addr_q;
        ram_wdata = set_bit(rmw_word_q, idx_q, val_q);
      end else if (accept && is_ram && MEM_WR && !MEM_BIT) begin
        ram_we = 1'b1;
      end
    end
  end

  // RAM array, never reset
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q         <= '0;
      bit_q         <= 1'b0;
      idx_q         <= '0;
      val_q         <= 1'b0;
      rmw_addr_q    <= '0;
      rmw_word_q    <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      err_q         <= 1'b0;
      sfr_addr_q    <= '0;
      sfr_wr_data_q <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q <= '0;
            bit_q <= is_bit_wr;
            idx_q <= MEM_BIT_IDX;
            val_q <= MEM_BIT_VAL;
            if (is_ram) begin
              if (is_bit_wr) begin
                rmw_addr_q <= ram_raddr;
                rmw_word_q <= ram[ram_raddr];
              end else if (!MEM_WR) begin
                // A read colliding with a write is dropped.
                rd_data_q  <= ram[ram_raddr];
                rd_valid_q <= 1'b1;
              end
            end else begin
              sfr_addr_q <= MEM_ADDR;
              if (MEM_WR && !MEM_BIT) sfr_wr_data_q <= MEM_WR_DATA;
            end
          end
        end
        StSfrWait: begin
          if (SFR_RD_VALID) begin
            if (bit_q) begin
              sfr_wr_data_q <= set_bit(SFR_RD_DATA, idx_q, val_q);
            end else begin
              rd_data_q  <= SFR_RD_DATA;
              rd_valid_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (!bit_q) begin
              rd_data_q  <= '1;
              rd_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dmem.sv
// Directed self-checking bench for cpu_dmem: a table of single-cycle RAM vectors plus
// hand-written sequences for SFR handshakes, timeout and reset during a sequence.
module tb_cpu_dmem;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] MEM_ADDR;
  logic [7:0] MEM_WR_DATA;
  logic       MEM_WR;
  logic       MEM_RD;
  logic       MEM_BIT;
  logic [2:0] MEM_BIT_IDX;
  logic       MEM_BIT_VAL;
  logic       MEM_BUSY;
  logic [7:0] MEM_RD_DATA;
  logic       MEM_RD_VALID;
  logic       MEM_ERR;
  logic [7:0] SFR_ADDR;
  logic [7:0] SFR_WR_DATA;
  logic       SFR_WR;
  logic       SFR_RD;
  logic [7:0] SFR_RD_DATA;
  logic       SFR_RD_VALID;

  int checks   = 0;
  int failures = 0;

  cpu_dmem #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .SFR_BASE  (128),
    .TIMEOUT   (16)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WR_DATA (MEM_WR_DATA),
    .MEM_WR      (MEM_WR),
    .MEM_RD      (MEM_RD),
    .MEM_BIT     (MEM_BIT),
    .MEM_BIT_IDX (MEM_BIT_IDX),
    .MEM_BIT_VAL (MEM_BIT_VAL),
    .MEM_BUSY    (MEM_BUSY),
    .MEM_RD_DATA (MEM_RD_DATA),
    .MEM_RD_VALID(MEM_RD_VALID),
    .MEM_ERR     (MEM_ERR),
    .SFR_ADDR    (SFR_ADDR),
    .SFR_WR_DATA (SFR_WR_DATA),
    .SFR_WR      (SFR_WR),
    .SFR_RD      (SFR_RD),
    .SFR_RD_DATA (SFR_RD_DATA),
    .SFR_RD_VALID(SFR_RD_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rd;
    logic       wr;
    logic       bw;
    logic [2:0] idx;
    logic       bval;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic rd, input logic wr, input logic bw,
                              input logic [2:0] idx, input logic bval, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic ev, input logic [7:0] ed,
                              input logic eb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bw = bw; v.idx = idx; v.bval = bval;
    v.addr = addr; v.wdata = wdata; v.e_valid = ev; v.e_data = ed; v.e_busy = eb;
    return v;
  endfunction

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic bw, input logic [2:0] idx,
                     input logic bval, input logic [7:0] addr, input logic [7:0] wdata);
    MEM_RD = rd; MEM_WR = wr; MEM_BIT = bw; MEM_BIT_IDX = idx; MEM_BIT_VAL = bval;
    MEM_ADDR = addr; MEM_WR_DATA = wdata;
  endtask

  task automatic idle_in();
    req(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_busy"}, MEM_BUSY, 1'b0);
    chk1({tag, "_valid"}, MEM_RD_VALID, 1'b0);
    chk1({tag, "_err"}, MEM_ERR, 1'b0);
    chk1({tag, "_sfr_wr"}, SFR_WR, 1'b0);
    chk1({tag, "_sfr_rd"}, SFR_RD, 1'b0);
    chk8({tag, "_rd_data"}, MEM_RD_DATA, 8'h00);
    chk8({tag, "_sfr_addr"}, SFR_ADDR, 8'h00);
    chk8({tag, "_sfr_wdata"}, SFR_WR_DATA, 8'h00);
  endtask

  task automatic ram_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, addr, 8'h00);
    step();
    idle_in();
    chk1({tag, "_valid"}, MEM_RD_VALID, 1'b1);
    chk8({tag, "_data"}, MEM_RD_DATA, exp);
  endtask

  task automatic sfr_bitwr(input string tag, input logic [7:0] addr, input logic [2:0] idx,
                           input logic val, input logic [7:0] rdata, input logic [7:0] expw);
    int wr_cnt;
    req(1'b0, 1'b1, 1'b1, idx, val, addr, 8'h00);
    step();
    idle_in();
    chk1({tag, "_rd"}, SFR_RD, 1'b1);
    SFR_RD_VALID = 1'b1;
    SFR_RD_DATA  = rdata;
    step();
    SFR_RD_VALID = 1'b0;
    chk1({tag, "_wr"}, SFR_WR, 1'b1);
    chk8({tag, "_wdata"}, SFR_WR_DATA, expw);
    chk8({tag, "_addr"}, SFR_ADDR, addr);
    chk1({tag, "_rd_low"}, SFR_RD, 1'b0);
    chk1({tag, "_no_valid"}, MEM_RD_VALID, 1'b0);
    wr_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (SFR_WR === 1'b1) wr_cnt++;
    end
    chk8({tag, "_extra_wr"}, 8'(wr_cnt), 8'd0);
    chk1({tag, "_idle"}, MEM_BUSY, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  wr_cnt;
    logic done;
    logic early;

    // RAM vectors: inputs for one edge, expected outputs just after it.
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h11, 8'hA5, 1'b0, 8'h00, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h11, 8'h00, 1'b1, 8'hA5, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h20, 8'h0F, 1'b0, 8'hA5, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 8'h20, 8'h00, 1'b0, 8'hA5, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h20, 8'h00, 1'b0, 8'hA5, 1'b1);
    // Presented while busy: ignored.
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 8'h00, 1'b0, 8'hA5, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h8E, 1'b0);
    // Read and write together: write wins, no strobe.
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h05, 8'h77, 1'b0, 8'h8E, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h05, 8'h00, 1'b1, 8'h77, 1'b0);
    // MEM_BIT with a read is a plain read.
    tbl[13] = mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h7F, 8'hC3, 1'b0, 8'h5A, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h7F, 8'h00, 1'b1, 8'hC3, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0);

    RST_N        = 1'b0;
    SFR_RD_VALID = 1'b0;
    SFR_RD_DATA  = 8'h00;
    idle_in();
    step();
    step();
    chk_zero("reset");
    RST_N = 1'b1;

    for (int i = 0; i < 17; i++) begin
      req(tbl[i].rd, tbl[i].wr, tbl[i].bw, tbl[i].idx, tbl[i].bval, tbl[i].addr, tbl[i].wdata);
      step();
      chk1($sformatf("vec%0d_valid", i), MEM_RD_VALID, tbl[i].e_valid);
      chk8($sformatf("vec%0d_data", i), MEM_RD_DATA, tbl[i].e_data);
      chk1($sformatf("vec%0d_busy", i), MEM_BUSY, tbl[i].e_busy);
      chk1($sformatf("vec%0d_err", i), MEM_ERR, 1'b0);
      chk1($sformatf("vec%0d_sfr", i), SFR_WR | SFR_RD, 1'b0);
    end
    idle_in();

    // SFR word write at the first SFR address.
    req(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h80, 8'h99);
    step();
    idle_in();
    chk1("sfrw_wr", SFR_WR, 1'b1);
    chk8("sfrw_addr", SFR_ADDR, 8'h80);
    chk8("sfrw_wdata", SFR_WR_DATA, 8'h99);
    chk1("sfrw_busy", MEM_BUSY, 1'b1);
    chk1("sfrw_rd", SFR_RD, 1'b0);
    step();
    chk1("sfrw_wr_end", SFR_WR, 1'b0);
    chk1("sfrw_busy_end", MEM_BUSY, 1'b0);

    // Stray SFR valid while idle.
    SFR_RD_VALID = 1'b1;
    SFR_RD_DATA  = 8'h11;
    step();
    SFR_RD_VALID = 1'b0;
    chk1("stray_valid", MEM_RD_VALID, 1'b0);
    chk8("stray_data", MEM_RD_DATA, 8'h5A);

    // SFR read, responder answers 3 cycles after SFR_RD rises.
    req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h90, 8'h00);
    step();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("sfrr_rd%0d", k), SFR_RD, 1'b1);
      chk8($sformatf("sfrr_addr%0d", k), SFR_ADDR, 8'h90);
      chk1($sformatf("sfrr_novalid%0d", k), MEM_RD_VALID, 1'b0);
      if (k == 3) begin
        SFR_RD_VALID = 1'b1;
        SFR_RD_DATA  = 8'h3C;
      end
      step();
    end
    SFR_RD_VALID = 1'b0;
    chk1("sfrr_valid", MEM_RD_VALID, 1'b1);
    chk8("sfrr_data", MEM_RD_DATA, 8'h3C);
    chk1("sfrr_err", MEM_ERR, 1'b0);
    chk1("sfrr_rd_low", SFR_RD, 1'b0);
    chk1("sfrr_busy", MEM_BUSY, 1'b0);

    // SFR timeout, no responder.
    req(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'hA0, 8'h00);
    step();
    idle_in();
    n     = 0;
    done  = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (SFR_RD !== 1'b1) begin
        done = 1'b1;
        break;
      end
      n++;
      if (MEM_ERR === 1'b1 || MEM_RD_VALID === 1'b1) early = 1'b1;
      step();
    end
    chk1("to_bound", done, 1'b1);
    chk8("to_cycles", 8'(n), 8'd16);
    chk1("to_early", early, 1'b0);
    chk1("to_err", MEM_ERR, 1'b1);
    chk1("to_valid", MEM_RD_VALID, 1'b1);
    chk8("to_data", MEM_RD_DATA, 8'hFF);
    chk1("to_busy", MEM_BUSY, 1'b0);
    step();
    chk1("to_err_pulse", MEM_ERR, 1'b0);
    chk1("to_valid_pulse", MEM_RD_VALID, 1'b0);

    // SFR bit writes with minimum-latency responses.
    sfr_bitwr("sbw0", 8'hB0, 3'd3, 1'b1, 8'h00, 8'h08);
    sfr_bitwr("sbw1", 8'hFF, 3'd5, 1'b0, 8'hFF, 8'hDF);

    // Reset during a RAM read-modify-write: no write-back.
    req(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h11, 8'h00);
    step();
    idle_in();
    chk1("rstrmw_busy", MEM_BUSY, 1'b1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    chk1("rstrmw_idle", MEM_BUSY, 1'b0);
    ram_read("rstrmw_keep", 8'h11, 8'hA5);

    // Reset during SFR_WAIT of a bit write.
    req(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB4, 8'h00);
    step();
    idle_in();
    chk1("rstsfr_wait", SFR_RD, 1'b1);
    RST_N        = 1'b0;
    SFR_RD_VALID = 1'b1;
    SFR_RD_DATA  = 8'h00;
    step();
    RST_N        = 1'b1;
    SFR_RD_VALID = 1'b0;
    chk_zero("rstsfr");
    wr_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (SFR_WR === 1'b1) wr_cnt++;
    end
    chk8("rstsfr_no_wr", 8'(wr_cnt), 8'd0);
    ram_read("rstsfr_ram10", 8'h10, 8'h5A);
    ram_read("rstsfr_ram20", 8'h20, 8'h8E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_dmem.md
# cpu_dmem

Parametrised internal data memory controller for the qwic51 CPU core. Internal RAM occupies addresses below `SFR_BASE`; all addresses at or above it are forwarded to an external SFR bus with a valid handshake and a timeout. The block adds single-instruction bit set/clear as a read-modify-write sequence and reports a data-valid strobe aligned to the returned data. It sits between the CPU execution unit and the IO/PC/arithmetic register files.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width.
- `ADDR_WIDTH`, 8: address width.
- `SFR_BASE`, 128: first SFR address. RAM depth equals `SFR_BASE`. Must be at most 2**`ADDR_WIDTH`.
- `TIMEOUT`, 16: maximum number of wait cycles for an SFR read. Must be at least 1.

Ports. `BW` = $clog2(`DATA_WIDTH`):
- `CLK` in 1: the single clock. All logic is on its rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `MEM_ADDR` in `ADDR_WIDTH`: request address.
- `MEM_WR_DATA` in `DATA_WIDTH`: write data.
- `MEM_WR` in 1: write request.
- `MEM_RD` in 1: read request.
- `MEM_BIT` in 1: qualifies `MEM_WR` as a bit write.
- `MEM_BIT_IDX` in `BW`: index of the bit to modify.
- `MEM_BIT_VAL` in 1: value written to that bit.
- `MEM_BUSY` out 1: high when the block cannot accept a request.
- `MEM_RD_DATA` out `DATA_WIDTH`: read data. Holds its value until the next `MEM_RD_VALID`.
- `MEM_RD_VALID` out 1: one-cycle strobe marking `MEM_RD_DATA` as valid.
- `MEM_ERR` out 1: one-cycle strobe on SFR timeout.
- `SFR_ADDR` out `ADDR_WIDTH`: SFR bus address.
- `SFR_WR_DATA` out `DATA_WIDTH`: SFR bus write data.
- `SFR_WR` out 1: SFR write strobe, one cycle.
- `SFR_RD` out 1: SFR read request. Held until valid or timeout.
- `SFR_RD_DATA` in `DATA_WIDTH`: SFR bus read data.
- `SFR_RD_VALID` in 1: SFR bus read-data valid.

## Operation
- **Acceptance.** A request is accepted on a rising edge where (`MEM_RD` | `MEM_WR`) & !`MEM_BUSY`. `MEM_BUSY` = (state != IDLE). Requests presented while busy are ignored; the requester must hold them.
- **Simultaneous `MEM_RD` and `MEM_WR`.** The write is performed and the read is dropped. No `MEM_RD_VALID` is produced.
- **Address decode.** `MEM_ADDR` < `SFR_BASE` goes to RAM; anything else goes to SFR. Decode is on the accepted address only.
- **States.** IDLE, RAM_RMW, SFR_WAIT, SFR_WB. Transitions:
  - RAM read: stays in IDLE. Synchronous RAM read. Fully pipelined, one read per cycle.
  - RAM word write: written at the accept edge. Stays in IDLE.
  - RAM bit write: the accept edge reads the word and latches address, index and value, then IDLE -> RAM_RMW. In RAM_RMW the word is written back with bit `MEM_BIT_IDX` replaced by `MEM_BIT_VAL`, then RAM_RMW -> IDLE. `MEM_RD_VALID` is not asserted.
  - SFR word write: latch address and data, IDLE -> SFR_WB. In SFR_WB, `SFR_WR` = 1 with the latched values, then SFR_WB -> IDLE.
  - SFR read or SFR bit write: latch the request, IDLE -> SFR_WAIT. In SFR_WAIT, `SFR_RD` = 1 and `SFR_ADDR` is held. The timeout counter clears on entry and increments each SFR_WAIT cycle.
    - `SFR_RD_VALID` is sampled high in SFR_WAIT (this includes the first SFR_WAIT cycle): capture `SFR_RD_DATA`.
      - For a read: `MEM_RD_DATA` = captured data, `MEM_RD_VALID` pulses, state -> IDLE.
      - For a bit write: build the modified word into `SFR_WR_DATA`, state -> SFR_WB.
    - Counter reaches `TIMEOUT` with no valid: `SFR_RD` drops, `MEM_ERR` pulses, state -> IDLE.
      - For a read: `MEM_RD_DATA` = all ones and `MEM_RD_VALID` pulses.
      - For a bit write: no SFR write is issued.
    - `SFR_RD_VALID` outside SFR_WAIT is ignored.
- **Bit ops.** Only bit `MEM_BIT_IDX` changes. All other bits keep the value that was read. `MEM_BIT` with `MEM_RD` alone is treated as a plain read.
- **Reset.** While `RST_N` = 0 at an edge:
  - state -> IDLE and the counter clears.
  - `MEM_BUSY`, `MEM_RD_VALID`, `MEM_ERR`, `SFR_WR` and `SFR_RD` go to 0.
  - `MEM_RD_DATA`, `SFR_ADDR` and `SFR_WR_DATA` go to 0.
  - RAM contents are not cleared.
  - Reset mid-operation abandons the sequence: no write-back, no `MEM_RD_VALID`, no `MEM_ERR`.

## Timing
- **RAM read.** Accepted at edge N -> `MEM_RD_VALID` = 1 with data during cycle N+1. Back-to-back reads return back-to-back.
- **RAM write then read of the same address.** Write at edge N, read accepted at edge N+1 -> new data is returned in cycle N+2.
- **RAM bit write.** Busy during cycle N+1 only. The next request can be accepted at edge N+2.
- **SFR write.** `SFR_WR` is high during cycle N+1 and busy during N+1.
- **SFR read.** `SFR_RD` is high from cycle N+1.
  - Valid sampled at edge N+k -> `MEM_RD_VALID` in cycle N+k+1 and `SFR_RD` low in cycle N+k+1.
  - Minimum latency is 2 cycles.
- **SFR timeout.** `TIMEOUT` cycles of `SFR_RD` high, then `MEM_ERR` and the all-ones `MEM_RD_VALID` in the next cycle.
- **SFR bit write.** `SFR_WR` is high in the cycle after valid is sampled.

## Test plan
- **RAM reads back-to-back.** Write 0x5A to 0x10 and 0xA5 to 0x11, then read 0x10 and 0x11 on consecutive cycles -> `MEM_RD_VALID` high two consecutive cycles with 0x5A then 0xA5; `MEM_BUSY` stays 0.
- **RAM bit write.** RAM 0x20 = 0x0F; bit write idx 7, val 1, then idx 0, val 0 -> read returns 0x8E. `MEM_BUSY` is high exactly one cycle per bit write.
- **SFR read with wait.** Read 0x90 with an SFR model that responds 3 cycles after `SFR_RD` rises, data 0x3C -> `SFR_ADDR` = 0x90 is held; `MEM_RD_DATA` = 0x3C; `MEM_ERR` = 0; `SFR_RD` low after valid.
- **SFR timeout.** Read 0xA0 with no responder, `TIMEOUT` = 16 -> after 16 `SFR_RD` cycles, `MEM_ERR` and `MEM_RD_VALID` pulse together with data 0xFF.
- **SFR bit write and collision.** SFR 0xB0 returns 0x00; bit write idx 3, val 1 -> one `SFR_WR` with 0x08. In the same run, assert `MEM_RD` and `MEM_WR` together on RAM 0x05 with data 0x77 -> no valid strobe, and a later read returns 0x77.
- **Reset mid-operation.** Assert `RST_N` low during SFR_WAIT of a bit write -> next cycle all outputs are 0, no `SFR_WR` is issued, and RAM contents are retained.
